// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub: request side (start, sub, a, b)
// and result side (busy, done, sum, cout, ovf).
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB chunk first,
// with a rippled carry register. Subtract is a + ~b + 1.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_addsub_if.slave   bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_addsub: WIDTH must be >=2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;     // shifts right one chunk per cycle
  logic [WIDTH-1:0] opb;     // b or ~b, shifts with opa
  logic             a_msb;   // operand sign bits kept for the overflow test
  logic             b_msb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res;     // chunks enter at the top and shift down

  logic [DIGIT:0]   csum;
  logic [WIDTH-1:0] res_nxt;

  // One chunk of the ripple sum, and the result register after inserting it.
  always_comb begin
    csum    = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    res_nxt = WIDTH'({csum[DIGIT-1:0], res} >> DIGIT);
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      carry    <= 1'b0;
      cnt      <= '0;
      res      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            opa      <= bus.a;
            opb      <= bus.sub ? ~bus.b : bus.b;
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            carry    <= bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= BUSY;
          end else begin
            state    <= IDLE;
          end
        end
        BUSY: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= csum[DIGIT];
          res   <= res_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            bus.sum  <= res_nxt;
            bus.cout <= csum[DIGIT];
            bus.ovf  <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three builds (DIGIT=4, 1, 16) with a scoreboard
// per build; expected results come from plain integer arithmetic.
module tb_serial_addsub;
  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[3][$];
  exp_t last[3];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(16)) if4  ();
  serial_addsub_if #(.WIDTH(16)) if1  ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  serial_addsub #(.WIDTH(16), .DIGIT(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_addsub #(.WIDTH(16), .DIGIT(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_addsub #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r      = ua - ub;
      sr     = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub;
      sr     = sa + sb;
      e.cout = (r > 65535);
    end
    e.sum = r[15:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon_one(input int i, input logic dn, input logic [15:0] s,
                         input logic c, input logic o);
    exp_t e;
    if (!rst_n) begin
      last[i] = '{sum: 16'h0, cout: 1'b0, ovf: 1'b0};
      chk($sformatf("reset_out%0d", i), {12'h0, dn, s, c, o}, 32'h0);
    end else if (dn) begin
      if (q[i].size() == 0) begin
        chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
      end else begin
        e = q[i].pop_front();
        chk($sformatf("result%0d", i), {13'h0, s, c, o}, {13'h0, e.sum, e.cout, e.ovf});
        last[i] = e;
      end
    end else begin
      chk($sformatf("hold%0d", i), {13'h0, s, c, o},
          {13'h0, last[i].sum, last[i].cout, last[i].ovf});
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_one(0, if4.done,  if4.sum,  if4.cout,  if4.ovf);
      mon_one(1, if1.done,  if1.sum,  if1.cout,  if1.ovf);
      mon_one(2, if16.done, if16.sum, if16.cout, if16.ovf);
    end
  endtask

  // Issue one op to the DIGIT=4 build; returns at the negedge after E0.
  task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    if4.start = 1'b1; if4.a = a; if4.b = b; if4.sub = s;
    @(posedge clk);
    q[0].push_back(model(a, b, s));
    @(negedge clk);
    if4.start = 1'b0; if4.a = 16'($urandom); if4.b = 16'($urandom); if4.sub = 1'($urandom);
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s);
    start4(a, b, s);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    for (int i = 0; i < 3; i++) last[i] = '{sum: 16'h0, cout: 1'b0, ovf: 1'b0};
    if4.start = 0;  if4.sub = 0;  if4.a = 0;  if4.b = 0;
    if1.start = 0;  if1.sub = 0;  if1.a = 0;  if1.b = 0;
    if16.start = 0; if16.sub = 0; if16.a = 0; if16.b = 0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, if4.busy}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // 1: basic add with busy/done timing
    @(negedge clk);
    if4.start = 1'b1; if4.a = 16'h1234; if4.b = 16'h4321; if4.sub = 1'b0;
    @(posedge clk);
    q[0].push_back(model(16'h1234, 16'h4321, 1'b0));
    #1 chk("busy_e0", {30'h0, if4.busy, if4.done}, 32'h2);
    @(negedge clk);
    if4.start = 1'b0; if4.a = 16'hFFFF; if4.b = 16'hFFFF; if4.sub = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1 chk($sformatf("busy_e%0d", k), {30'h0, if4.busy, if4.done}, 32'h2);
    end
    @(posedge clk); #1 chk("done_e4", {30'h0, if4.busy, if4.done}, 32'h1);
    @(posedge clk); #1 chk("idle_e5", {30'h0, if4.busy, if4.done}, 32'h0);

    // 2/3: carry, overflow and borrow corners
    op4(16'hFFFF, 16'h0001, 1'b0);
    op4(16'h7FFF, 16'h0001, 1'b0);
    op4(16'h0005, 16'h0007, 1'b1);
    op4(16'h8000, 16'h0001, 1'b1);

    // 4: start while busy ignored, start during DONE accepted
    start4(16'h0010, 16'h0020, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b1; if4.a = 16'hFFFF; if4.b = 16'hFFFF; if4.sub = 1'b0;
    @(posedge clk); #1 chk("busy_ignore", {31'h0, if4.busy}, 32'h1);
    @(negedge clk); if4.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 chk("done_first", {31'h0, if4.done}, 32'h1);
    @(negedge clk);
    if4.start = 1'b1; if4.a = 16'h0100; if4.b = 16'h0001; if4.sub = 1'b1;
    @(posedge clk);
    q[0].push_back(model(16'h0100, 16'h0001, 1'b1));
    #1 chk("b2b_busy", {30'h0, if4.busy, if4.done}, 32'h2);
    @(negedge clk); if4.start = 1'b0; if4.a = 16'h5A5A; if4.b = 16'hA5A5; if4.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("b2b_not_yet", {31'h0, if4.done}, 32'h0);
    @(posedge clk); #1 chk("b2b_done", {31'h0, if4.done}, 32'h1);
    @(posedge clk);

    // 5: reset mid-operation aborts with no done
    start4(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("abort_regs", {12'h0, if4.busy, if4.done, if4.sum, if4.cout, if4.ovf}, 32'h0);
    q[0].delete();
    @(negedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 chk("no_done_after_abort", {31'h0, if4.done}, 32'h0);
    end
    op4(16'h0001, 16'h0001, 1'b0);

    // 6: random ops on all three builds, spaced for the slowest (N=16)
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (n < 8) begin
        ra = (n[0]) ? 16'h8000 : 16'h7FFF;
        rb = (n[1]) ? 16'hFFFF : 16'h0001;
        rs = n[2];
      end
      @(negedge clk);
      if4.start = 1; if4.a = ra; if4.b = rb; if4.sub = rs;
      if1.start = 1; if1.a = ra; if1.b = rb; if1.sub = rs;
      if16.start = 1; if16.a = ra; if16.b = rb; if16.sub = rs;
      @(posedge clk);
      for (int i = 0; i < 3; i++) q[i].push_back(model(ra, rb, rs));
      @(negedge clk);
      if4.start = 0;  if4.a = 16'($urandom);  if4.b = 16'($urandom);  if4.sub = 1'($urandom);
      if1.start = 0;  if1.a = 16'($urandom);  if1.b = 16'($urandom);  if1.sub = 1'($urandom);
      if16.start = 0; if16.a = 16'($urandom); if16.b = 16'($urandom); if16.sub = 1'($urandom);
      repeat (16) @(posedge clk);
      repeat ($urandom_range(0, 1)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), q[i].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the single-bit half-adder cells.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB chunk first, with a rippled carry register.
- Runs a start/done handshake and reports carry/borrow and signed overflow.
- Used where area matters more than latency; DIGIT trades cycles for adder width.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
DIGIT, 4, bits processed per cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise); N = WIDTH/DIGIT cycles per operation

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
sub  in  1  0 = a+b, 1 = a-b; sampled with start
a  in  WIDTH  operand A; sampled with start
b  in  WIDTH  operand B; sampled with start
busy  out  1  high while chunks are being processed
done  out  1  one-cycle pulse; results valid
sum  out  WIDTH  result, modulo 2^WIDTH
cout  out  1  carry out of MSB (subtract: 1 = no borrow)
ovf  out  1  two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy, done, sum, cout, ovf = 0; internal operand, carry and count registers = 0.
  - Mid-operation reset aborts the operation; no done is issued.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start=1 -> BUSY.
  - BUSY: after the Nth chunk -> DONE.
  - DONE: lasts exactly 1 cycle; start=1 -> BUSY (back-to-back), else -> IDLE.
- Accepting start (edge E0):
  - Latch A=a and B'=(sub ? ~b : b).
  - Carry register = sub.
  - Chunk index = 0.
  - busy=1 from E0.
- BUSY:
  - Edge Ek (k=1..N): {c, r} = A[chunk] + B'[chunk] + carry over DIGIT bits.
  - Chunk result is stored into an internal result register at bit offset (k-1)*DIGIT; carry updated.
- Edge EN:
  - sum = completed result register.
  - cout = final carry.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
  - busy=0; done=1 for the cycle EN..EN+1.
- Latency and throughput:
  - Start at E0 gives done high after EN.
  - Throughput is one operation per N+1 cycles with back-to-back starts.
- sum/cout/ovf update only at EN and hold until the next operation's EN. They do not change on start or during BUSY.
- start while BUSY: ignored; the in-flight operation and its latched operands are unaffected.
- Changes to a, b and sub after E0 have no effect.
- Degenerate cases:
  - DIGIT=WIDTH: N=1; done after E1.
  - DIGIT=1: pure bit-serial, N=WIDTH.
- Counter width is clog2(N)+1. No wrap beyond N is reachable.

Test Plan:
1. WIDTH=16, DIGIT=4: add 0x1234+0x4321 -> sum=0x5555, cout=0, ovf=0. busy high E0..E4; done high exactly one cycle after E4.
2. Add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0. Then add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Subtract 0x0005-0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then subtract 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Start 0x0010+0x0020. Pulse start with 0xFFFF+0xFFFF at E2 -> ignored; result sum=0x0030. Assert start with 0x0100-0x0001 during the DONE cycle -> accepted; second done 5 cycles later with sum=0x00FF, cout=1. a/b toggled after E0 have no effect.
5. rst_n low between E2 and E3 -> busy, done, sum, cout, ovf = 0 immediately; no done pulse. After release, 0x0001+0x0001 -> sum=0x0002.
6. Rebuild with DIGIT=1 (done after E16) and DIGIT=16 (done after E1). Run 1000 random a, b, sub operations each -> match a±b mod 2^16, cout, and ovf reference.
